// File: rtl/cnt_pkg.sv
// Constants and gate-level comparators shared by the mod-99 up and down counters.
// Counts are 7-bit binary and legal only in 0..98.
package cnt_pkg;

    localparam int CNT_W   = 7;
    localparam int CNT_MOD = 99;
    localparam int CNT_MAX = 98;

    // 98 = 7'b110_0010, decoded from individual bits
    function automatic logic is_max(input logic [CNT_W-1:0] v);
        return v[6] & v[5] & ~v[4] & ~v[3] & ~v[2] & v[1] & ~v[0];
    endfunction

    // v >= 99: must be at least 96, and bits 4..0 must be at least 3
    function automatic logic above_max(input logic [CNT_W-1:0] v);
        return v[6] & v[5] & (v[4] | v[3] | v[2] | (v[1] & v[0]));
    endfunction

endpackage

// File: rtl/mod_99_up_cnt_add7.sv
// 7-bit ripple-carry adder built from half/full adder cells.
// This is the adding counterpart of the down counter's 7-bit subtractor.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add7 (
    input  logic [6:0] a,
    input  logic [6:0] b,
    output logic [6:0] sum,
    output logic       cout
);
    logic [6:0] carry;

    half_add u_ha0 (.a(a[0]), .b(b[0]), .s(sum[0]), .c(carry[0]));

    generate
        for (genvar gi = 1; gi < 7; gi++) begin : g_fa
            full_add u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (carry[gi-1]),
                .s  (sum[gi]),
                .co (carry[gi])
            );
        end
    endgenerate

    assign cout = carry[6];
endmodule

// File: rtl/mod_99_up_cnt.sv
// Modulo-99 up counter with synchronous clear/load, a terminal-count decode
// and registered wrap / load-error pulses.
module mod_99_up_cnt
    import cnt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] count_inc;
    logic             add_cout_unused;
    logic             at_max, cnt_illegal, val_illegal;

    add7 u_add7 (
        .a    (count_q),
        .b    (7'd1),
        .sum  (count_inc),
        .cout (add_cout_unused)
    );

    assign at_max      = is_max(count_q);
    assign cnt_illegal = above_max(count_q);
    assign val_illegal = above_max(load_val);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            if (val_illegal) begin
                count_d    = '0;
                load_err_d = 1'b1;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (at_max) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else if (cnt_illegal) begin
                // upset state recovers to 0 silently, no wrap pulse
                count_d = '0;
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tc       = at_max;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_99_up_cnt.sv
// Self-checking bench for mod_99_up_cnt: reset, vector table, corner
// sequences, free-run and randomized traffic against an arithmetic model.
module tb_mod_99_up_cnt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en;
    logic [6:0] load_val;
    logic [6:0] count;
    logic       tc, wrap, load_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_count;
    int m_wrap;
    int m_err;

    typedef struct {
        bit      clr;
        bit      load;
        int      val;
        bit      en;
        int      exp_count;
        bit      exp_tc;
        bit      exp_wrap;
        bit      exp_err;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    mod_99_up_cnt dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit c, input bit l, input int v, input bit e);
        clr      = c;
        load     = l;
        load_val = 7'(v);
        en       = e;
    endtask

    // model advance: counting is (n + 1) mod 99, loads above 98 are rejected
    task automatic model_step(input bit c, input bit l, input int v, input bit e);
        m_wrap = 0;
        m_err  = 0;
        if (c) begin
            m_count = 0;
        end else if (l) begin
            if (v > 98) begin
                m_count = 0;
                m_err   = 1;
            end else begin
                m_count = v;
            end
        end else if (e) begin
            m_wrap  = (m_count == 98) ? 1 : 0;
            m_count = (m_count + 1) % 99;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_count"}, int'(count), m_count);
        chk({tag, "_tc"}, int'(tc), (m_count == 98) ? 1 : 0);
        chk({tag, "_wrap"}, int'(wrap), m_wrap);
        chk({tag, "_err"}, int'(load_err), m_err);
    endtask

    initial begin
        //            clr load val en  cnt tc wrap err
        vecs[0]  = '{0, 1, 50,  0, 50, 0, 0, 0};
        vecs[1]  = '{0, 0, 0,   1, 51, 0, 0, 0};
        vecs[2]  = '{0, 0, 0,   1, 52, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,   1, 53, 0, 0, 0};
        vecs[4]  = '{0, 1, 120, 0, 0,  0, 0, 1};
        vecs[5]  = '{0, 0, 0,   0, 0,  0, 0, 0};
        vecs[6]  = '{0, 1, 97,  0, 97, 0, 0, 0};
        vecs[7]  = '{0, 0, 0,   1, 98, 1, 0, 0};
        vecs[8]  = '{0, 0, 0,   0, 98, 1, 0, 0};
        vecs[9]  = '{0, 1, 7,   1, 7,  0, 0, 0};
        vecs[10] = '{0, 1, 98,  0, 98, 1, 0, 0};
        vecs[11] = '{0, 0, 0,   1, 0,  0, 1, 0};
        vecs[12] = '{0, 0, 0,   0, 0,  0, 0, 0};
        vecs[13] = '{0, 1, 40,  0, 40, 0, 0, 0};
        vecs[14] = '{1, 1, 10,  1, 0,  0, 0, 0};
        vecs[15] = '{0, 1, 98,  0, 98, 1, 0, 0};
        vecs[16] = '{1, 0, 0,   1, 0,  0, 0, 0};
        vecs[17] = '{0, 1, 99,  0, 0,  0, 0, 1};
        vecs[18] = '{0, 1, 0,   1, 0,  0, 0, 0};
        vecs[19] = '{0, 0, 0,   1, 1,  0, 0, 0};

        // reset and idle hold
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_err", int'(load_err), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_hold", int'(count), 0);
        end

        // 98 enabled cycles reach terminal count, the next one wraps
        set_in(0, 0, 0, 1);
        repeat (98) tick();
        chk("run98_count", int'(count), 98);
        chk("run98_tc", int'(tc), 1);
        chk("run98_wrap", int'(wrap), 0);
        tick();
        chk("wrap_count", int'(count), 0);
        chk("wrap_pulse", int'(wrap), 1);
        chk("wrap_tc", int'(tc), 0);
        set_in(0, 0, 0, 0);
        tick();
        chk("wrap_one_cycle", int'(wrap), 0);

        // vector table
        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].clr, vecs[i].load, vecs[i].val, vecs[i].en);
            tick();
            $display("vec %0d: clr=%0b load=%0b val=%0d en=%0b -> count=%0d tc=%0b wrap=%0b err=%0b",
                     i, vecs[i].clr, vecs[i].load, vecs[i].val, vecs[i].en,
                     count, tc, wrap, load_err);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
            chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d_err", i), int'(load_err), int'(vecs[i].exp_err));
        end
        set_in(0, 0, 0, 0);

        // asynchronous reset between edges at count 63
        set_in(0, 1, 63, 0);
        tick();
        set_in(0, 0, 0, 0);
        chk("pre_arst_count", int'(count), 63);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_tc", int'(tc), 0);
        chk("arst_wrap", int'(wrap), 0);
        chk("arst_err", int'(load_err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;
        tick();
        chk("post_arst_count", int'(count), 1);

        // free run from 0 for 500 cycles
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1);
        begin
            int wraps = 0;
            int over  = 0;
            m_count = 0;
            for (int i = 0; i < 500; i++) begin
                tick();
                model_step(0, 0, 0, 1);
                if (count != 7'(m_count)) begin
                    chk("free_count", int'(count), m_count);
                end
                if (wrap) wraps++;
                if (count > 7'd98) over++;
            end
            chk("free_final_count", int'(count), m_count);
            chk("free_wraps", wraps, 5);
            chk("free_overrange", over, 0);
        end

        // randomized traffic against the model
        set_in(0, 0, 0, 0);
        tick();
        m_count = int'(count);
        for (int i = 0; i < 1500; i++) begin
            bit c, l, e;
            int v;
            c = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = (l && $urandom_range(0, 3) == 0) ? 98 : int'($urandom_range(0, 127));
            set_in(c, l, v, e);
            tick();
            model_step(c, l, v, e);
            chk_model("rand");
        end
        set_in(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard bound so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
